// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between fetch_unit and an Avalon-style instruction memory.
// The fetch unit drives the request side; the memory answers with data and waitrequest.
interface fetch_unit_if;
  logic [31:0] instr_address;
  logic        instr_read;
  logic [31:0] instr_readdata;
  logic        instr_waitrequest;

  modport master (
    output instr_address,
    output instr_read,
    input  instr_readdata,
    input  instr_waitrequest
  );

  modport slave (
    input  instr_address,
    input  instr_read,
    output instr_readdata,
    output instr_waitrequest
  );
endinterface

// File: rtl/fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches over an Avalon-style bus and handles
// j/jr with one delay slot plus the jump-to-HALT_ADDR halt. Optional macro: ALIGN_FAULT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input  logic               clk_i,
  input  logic               rst_i,
  fetch_unit_if.master       imem,
  input  logic               stall_i,
  input  logic               jump_i,
  input  logic               jr_i,
  input  logic [31:0]        jr_target_i,
  output logic [31:0]        pc_o,
  output logic [31:0]        ir_o,
  output logic               ir_valid_o,
  output logic               halted_o,
  output logic               fault_o
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalt} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] ir_q;
  logic [31:0] pend_target_q;
  logic        pend_q;
  logic        read_q;
  logic        ir_valid_q;
  logic        halted_q;
  logic        fault_q;

  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  logic [31:0] jr_target_lat;
  logic        pend_misaligned;

  assign pc_plus4    = pc_q + 32'd4;
  assign jump_target = {pc_plus4[31:28], ir_q[25:0], 2'b00};

`ifdef ALIGN_FAULT_EN
  // Keep the low bits so the misalignment can be reported when the delay slot retires.
  assign jr_target_lat   = jr_target_i;
  assign pend_misaligned = (pend_target_q[1:0] != 2'b00);
`else
  assign jr_target_lat   = {jr_target_i[31:2], 2'b00};
  assign pend_misaligned = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      pc_q          <= RESET_VECTOR;
      ir_q          <= 32'h0;
      pend_target_q <= 32'h0;
      pend_q        <= 1'b0;
      read_q        <= 1'b0;
      ir_valid_q    <= 1'b0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_q <= StFetch;
          read_q  <= 1'b1;
        end
        StFetch: begin
          if (!imem.instr_waitrequest) begin
            ir_q       <= imem.instr_readdata;
            read_q     <= 1'b0;
            ir_valid_q <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (!stall_i) begin
            ir_valid_q <= 1'b0;
            if (pend_q) begin
              // Delay slot retiring: redirect; any jump it carries is ignored.
              pend_q <= 1'b0;
              pc_q   <= pend_target_q;
              if (pend_misaligned) begin
                fault_q  <= 1'b1;
                halted_q <= 1'b1;
                state_q  <= StHalt;
              end else if (pend_target_q == HALT_ADDR) begin
                halted_q <= 1'b1;
                state_q  <= StHalt;
              end else begin
                read_q  <= 1'b1;
                state_q <= StFetch;
              end
            end else begin
              if (jr_i) begin
                pend_q        <= 1'b1;
                pend_target_q <= jr_target_lat;
              end else if (jump_i) begin
                pend_q        <= 1'b1;
                pend_target_q <= jump_target;
              end
              pc_q    <= pc_plus4;
              read_q  <= 1'b1;
              state_q <= StFetch;
            end
          end
        end
        StHalt: begin
        end
      endcase
    end
  end

  assign imem.instr_address = pc_q;
  assign imem.instr_read    = read_q;
  assign pc_o               = pc_q;
  assign ir_o               = ir_q;
  assign ir_valid_o         = ir_valid_q;
  assign halted_o           = halted_q;
  assign fault_o            = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset timing, waitrequest hold, stall, j/jr delay slot,
// halt, pc wrap and misaligned jr (behaviour depends on ALIGN_FAULT_EN).
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall, jump, jr;
  logic [31:0] jr_target;
  logic [31:0] pc, ir;
  logic        ir_valid, halted, fault;
  int          n_tests = 0;
  int          n_fail  = 0;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .imem        (bus),
    .stall_i     (stall),
    .jump_i      (jump),
    .jr_i        (jr),
    .jr_target_i (jr_target),
    .pc_o        (pc),
    .ir_o        (ir),
    .ir_valid_o  (ir_valid),
    .halted_o    (halted),
    .fault_o     (fault)
  );

  always #5 clk = ~clk;

  // Program words at a few addresses; everything else reads back as ~address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC00000: mem_word = 32'h24020005;
      32'hBFC00008: mem_word = 32'h08000010;
      32'hBFC00010: mem_word = 32'h03E00008;
      default:      mem_word = ~a;
    endcase
  endfunction

  always_comb bus.instr_readdata = mem_word(bus.instr_address);

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    stall = 1'b0; jump = 1'b0; jr = 1'b0; jr_target = 32'h0;
    bus.instr_waitrequest = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_issue(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (ir_valid) begin
        ok = 1'b1;
        return;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stall = 1'b0; jump = 1'b0; jr = 1'b0; jr_target = 32'h0;
    bus.instr_waitrequest = 1'b0;
    step();
    n_tests++;
    if (pc !== 32'hBFC00000 || ir !== 32'h0 || ir_valid !== 1'b0 || bus.instr_read !== 1'b0 ||
        halted !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: pc=%h ir=%h v=%b rd=%b h=%b f=%b want bfc00000 0 0 0 0 0",
               pc, ir, ir_valid, bus.instr_read, halted, fault);
    end
    step();
    rst = 1'b0;
    n_tests++;
    if (bus.instr_read !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_read: read=%b want 0", bus.instr_read);
    end
    step();
    n_tests++;
    if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC00000) begin
      n_fail++;
      $display("FAIL first_fetch: read=%b addr=%h want 1 bfc00000", bus.instr_read,
               bus.instr_address);
    end
    step();
    n_tests++;
    if (ir_valid !== 1'b1 || ir !== 32'h24020005 || pc !== 32'hBFC00000 ||
        bus.instr_read !== 1'b0) begin
      n_fail++;
      $display("FAIL first_issue: v=%b ir=%h pc=%h rd=%b want 1 24020005 bfc00000 0",
               ir_valid, ir, pc, bus.instr_read);
    end
    step();
    n_tests++;
    if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC00004 || ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL second_fetch: read=%b addr=%h v=%b want 1 bfc00004 0", bus.instr_read,
               bus.instr_address, ir_valid);
    end
  endtask

  task automatic test_waitrequest();
    do_reset();
    step();
    step();
    bus.instr_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_tests++;
      if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC00004 ||
          ir !== 32'h24020005 || ir_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL wait_hold[%0d]: rd=%b addr=%h ir=%h v=%b want 1 bfc00004 24020005 0",
                 i, bus.instr_read, bus.instr_address, ir, ir_valid);
      end
    end
    bus.instr_waitrequest = 1'b0;
    step();
    n_tests++;
    if (ir !== 32'h403FFFFB || ir_valid !== 1'b1 || pc !== 32'hBFC00004) begin
      n_fail++;
      $display("FAIL wait_done: ir=%h v=%b pc=%h want 403ffffb 1 bfc00004", ir, ir_valid, pc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    step();
    bus.instr_waitrequest = 1'b1;
    step();
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if (bus.instr_read !== 1'b0 || pc !== 32'hBFC00000 || ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fetch: rd=%b pc=%h v=%b want 0 bfc00000 0", bus.instr_read, pc,
               ir_valid);
    end
    bus.instr_waitrequest = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (ir_valid !== 1'b1 || pc !== 32'hBFC00000 || ir !== 32'h24020005 ||
          bus.instr_read !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: v=%b pc=%h ir=%h rd=%b want 1 bfc00000 24020005 0",
                 i, ir_valid, pc, ir, bus.instr_read);
      end
    end
    stall = 1'b0;
    step();
    n_tests++;
    if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC00004 || ir_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: rd=%b addr=%h v=%b want 1 bfc00004 0", bus.instr_read,
               bus.instr_address, ir_valid);
    end
  endtask

  task automatic test_jump();
    bit ok;
    do_reset();
    wait_issue(ok);
    step();
    wait_issue(ok);
    step();
    wait_issue(ok);
    n_tests++;
    if (!ok || pc !== 32'hBFC00008 || ir !== 32'h08000010) begin
      n_fail++;
      $display("FAIL jump_issue: ok=%b pc=%h ir=%h want 1 bfc00008 08000010", ok, pc, ir);
    end
    jump = 1'b1;
    step();
    jump = 1'b0;
    n_tests++;
    if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC0000C) begin
      n_fail++;
      $display("FAIL jump_slot_fetch: rd=%b addr=%h want 1 bfc0000c", bus.instr_read,
               bus.instr_address);
    end
    wait_issue(ok);
    // A jump asserted in the delay slot must be ignored.
    jump = 1'b1;
    step();
    jump = 1'b0;
    n_tests++;
    if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hB0000040) begin
      n_fail++;
      $display("FAIL jump_target_fetch: rd=%b addr=%h want 1 b0000040", bus.instr_read,
               bus.instr_address);
    end
    wait_issue(ok);
    n_tests++;
    if (!ok || pc !== 32'hB0000040 || ir !== 32'h4FFFFFBF) begin
      n_fail++;
      $display("FAIL jump_target_issue: ok=%b pc=%h ir=%h want 1 b0000040 4fffffbf", ok, pc, ir);
    end
  endtask

  task automatic test_jr_halt();
    bit ok;
    bit bad;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wait_issue(ok);
      step();
    end
    wait_issue(ok);
    n_tests++;
    if (!ok || pc !== 32'hBFC00010) begin
      n_fail++;
      $display("FAIL jr_issue: ok=%b pc=%h want 1 bfc00010", ok, pc);
    end
    // Both asserted: jr must win, so the target is 0 and the CPU halts.
    jr = 1'b1;
    jump = 1'b1;
    jr_target = 32'h0;
    step();
    jr = 1'b0;
    jump = 1'b0;
    n_tests++;
    if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hBFC00014) begin
      n_fail++;
      $display("FAIL jr_slot_fetch: rd=%b addr=%h want 1 bfc00014", bus.instr_read,
               bus.instr_address);
    end
    wait_issue(ok);
    n_tests++;
    if (!ok || pc !== 32'hBFC00014 || ir !== 32'h403FFFEB || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL jr_slot_issue: ok=%b pc=%h ir=%h h=%b want 1 bfc00014 403fffeb 0",
               ok, pc, ir, halted);
    end
    step();
    n_tests++;
    if (halted !== 1'b1 || bus.instr_read !== 1'b0 || ir_valid !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_entry: h=%b rd=%b v=%b f=%b want 1 0 0 0", halted, bus.instr_read,
               ir_valid, fault);
    end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.instr_read !== 1'b0 || halted !== 1'b1 || ir_valid !== 1'b0) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL halt_sticky: disturbed=%b want 0", bad);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    do_reset();
    wait_issue(ok);
    jr = 1'b1;
    jr_target = 32'hFFFFFFFC;
    step();
    jr = 1'b0;
    wait_issue(ok);
    step();
    n_tests++;
    if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'hFFFFFFFC) begin
      n_fail++;
      $display("FAIL wrap_top_fetch: rd=%b addr=%h want 1 fffffffc", bus.instr_read,
               bus.instr_address);
    end
    wait_issue(ok);
    step();
    n_tests++;
    if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'h0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_zero_fetch: rd=%b addr=%h h=%b want 1 00000000 0", bus.instr_read,
               bus.instr_address, halted);
    end
    wait_issue(ok);
    n_tests++;
    if (!ok || pc !== 32'h0 || ir !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL wrap_zero_issue: ok=%b pc=%h ir=%h want 1 00000000 ffffffff", ok, pc, ir);
    end
  endtask

  task automatic test_misaligned_jr();
    bit ok;
    bit bad;
    do_reset();
    wait_issue(ok);
    jr = 1'b1;
    jr_target = 32'h00400002;
    step();
    jr = 1'b0;
    wait_issue(ok);
    step();
`ifdef ALIGN_FAULT_EN
    n_tests++;
    if (fault !== 1'b1 || halted !== 1'b1 || bus.instr_read !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_fault: f=%b h=%b rd=%b want 1 1 0", fault, halted, bus.instr_read);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.instr_read !== 1'b0 || fault !== 1'b1 || halted !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_sticky: disturbed=%b want 0", bad);
    end
`else
    bad = (fault !== 1'b0) || (halted !== 1'b0);
    n_tests++;
    if (bus.instr_read !== 1'b1 || bus.instr_address !== 32'h00400000 || bad) begin
      n_fail++;
      $display("FAIL misalign_trunc: rd=%b addr=%h f=%b h=%b want 1 00400000 0 0",
               bus.instr_read, bus.instr_address, fault, halted);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_waitrequest();
    test_reset_mid_fetch();
    test_stall();
    test_jump();
    test_jr_halt();
    test_wrap();
    test_misaligned_jr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the datapath; owns the PC and supplies `pc`, `ir` and `ir_valid` to it.
- Talks to instruction memory with an Avalon-style read/waitrequest handshake.
- Implements MIPS jump/jr with one branch-delay slot.
- Detects the jump-to-zero halt convention.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC loaded on reset.
- HALT_ADDR, 32'h00000000, jump target that halts the CPU after its delay slot retires.

Ports:
- clk  in  1  clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- instr_address  out  32  fetch address (always equals pc)
- instr_read  out  1  fetch request
- instr_readdata  in  32  fetched word
- instr_waitrequest  in  1  memory not ready; read must be held
- stall  in  1  datapath cannot accept the current instruction (e.g. lw in progress)
- jump  in  1  current ir is a J-type jump (j/jal)
- jr  in  1  current ir is jr/jalr
- jr_target  in  32  register value for jr (rs)
- pc  out  32  address of instruction in ir
- ir  out  32  current instruction
- ir_valid  out  1  ir holds an instruction for the datapath
- halted  out  1  CPU has halted
- fault  out  1  misaligned jr target (only with ALIGN_FAULT_EN; tied 0 otherwise)

Behaviour:
- Reset (async, active-high):
  - state=IDLE, pc=RESET_VECTOR, ir=0, ir_valid=0, instr_read=0, halted=0, fault=0, pend=0, pend_target=0.
  - Reset asserted mid-fetch abandons the read immediately; no handshake completion is required.
- States: IDLE, FETCH, ISSUE, HALT.
- IDLE: one cycle after reset deasserts, then go to FETCH.
- FETCH:
  - instr_read=1, instr_address=pc, ir_valid=0.
  - While instr_waitrequest=1: hold the address and read, stay in FETCH.
  - On instr_waitrequest=0: ir<=instr_readdata, go to ISSUE.
- ISSUE:
  - ir_valid=1, instr_read=0.
  - stall=1: hold pc, ir and state; ignore jump/jr.
  - stall=0 retires the instruction, then:
    - pend=0 and jump=1: pend<=1, pend_target<={pc_plus4[31:28], ir[25:0], 2'b00}.
    - pend=0 and jr=1: pend<=1, pend_target<=jr_target.
    - pc<=pc+4, go to FETCH. This fetches the delay slot.
    - pend=1 (retiring the delay slot): pc<=pend_target, pend<=0.
      - If pend_target==HALT_ADDR, go to HALT.
      - Otherwise go to FETCH.
    - jump/jr asserted while pend=1 (jump in delay slot) is ignored.
    - jump and jr both high: jr takes priority.
- HALT: halted=1, ir_valid=0, instr_read=0; only reset exits.
- Throughput: with waitrequest always low, one instruction every 2 cycles.
  - First instr_read occurs in the 2nd cycle after reset release.
- pc arithmetic is modulo 2^32: pc+4 wraps 32'hFFFFFFFC to 32'h0.
  - A sequential wrap to 0 does NOT halt; only a jump target equal to HALT_ADDR does.
- Without ALIGN_FAULT_EN, jr_target[1:0] is forced to 00 when latched.

Optional Feature:
- Macro: ALIGN_FAULT_EN
- Defined:
  - A jr latched with jr_target[1:0]!=0 sets pend normally, keeping the target bits.
  - When the delay slot retires, fault<=1 and state goes to HALT.
  - halted=1 and fault remains 1 until reset.
- Undefined:
  - Low two bits are truncated and execution continues at the aligned address.
  - fault is constant 0.

Test Plan:
- Reset, waitrequest=0, memory returns 32'h24020005 at BFC00000 -> first instr_read at BFC00000 in cycle 2 after reset release; ir=24020005 and ir_valid=1 in cycle 3; next fetch at BFC00004.
- waitrequest high 3 cycles during fetch of BFC00004 -> address and read held for 4 cycles; ir updates only on the cycle waitrequest=0.
- stall=1 for 2 cycles in ISSUE -> pc, ir and ir_valid unchanged; fetch of pc+4 starts only after stall drops.
- j with ir[25:0]=26'h0000010 at pc=BFC00008 -> delay slot fetched at BFC0000C, then fetch at B0000040.
- jr with jr_target=0 at pc=BFC00010 -> delay slot at BFC00014 issues with ir_valid=1; then halted=1, instr_read stays 0 for 10+ cycles.
- ALIGN_FAULT_EN, jr_target=32'h00400002 -> after delay slot: fault=1, halted=1, no fetch at 00400002. Without the macro: next fetch at 00400000.
